lock_cycle_sequencer: RTL and testbench

//  Sequences one gondola passage through the canal lock: latches arrival/departure requests, equalizes

---
 rtl/lock_cycle_sequencer.sv | 152 +++++++++++++++
 tb/tb_lock_cycle_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_cycle_sequencer.sv
// Canal lock passage sequencer: arbitrates arrival/departure requests, equalizes chamber water
// to the side being opened, then opens that gate with a dwell on the occupancy condition.
module lock_cycle_sequencer #(
    parameter int LVL_W     = 7,
    parameter int INNER_LVL = 60,
    parameter int OUTER_LVL = 40,
    parameter int TOL       = 3,
    parameter int DWELL     = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arr_sw,
    input  logic             dept_sw,
    input  logic             gondola_in,
    input  logic [LVL_W-1:0] water_level,
    output logic             fill_en,
    output logic             drain_en,
    output logic             outer_open,
    output logic             inner_open,
    output logic             arr_led,
    output logic             dept_led,
    output logic             busy,
    output logic             fault
);

    localparam int LW = LVL_W + 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Band limits in one extra bit so T+TOL cannot wrap; the low edge saturates at 0.
    localparam logic [LW-1:0] OUT_LO = (OUTER_LVL > TOL) ? LW'(OUTER_LVL - TOL) : '0;
    localparam logic [LW-1:0] OUT_HI = LW'(OUTER_LVL + TOL);
    localparam logic [LW-1:0] IN_LO  = (INNER_LVL > TOL) ? LW'(INNER_LVL - TOL) : '0;
    localparam logic [LW-1:0] IN_HI  = LW'(INNER_LVL + TOL);

    typedef enum logic [2:0] {
        S_IDLE, S_EQ_OUT, S_OPEN_OUT, S_EQ_IN, S_OPEN_IN, S_FAULT
    } state_e;

    state_e        state_q;
    logic          arr_pend_q, dept_pend_q;
    logic          last_arr_q;   // 1 = last served passage was an arrival
    logic          srv_arr_q;    // direction of the passage in progress
    logic          leg_q;        // 0 = gondola entering, 1 = gondola leaving
    logic [DW-1:0] dwell_q;
    logic [TW-1:0] tmo_q;

    logic [LW-1:0] lvl;
    logic out_below, out_above, in_below, in_above;
    logic side_out, cur_below, cur_above, cur_ok, oth_below, oth_above;
    logic occ_ok, pick_arr;

    assign lvl       = {1'b0, water_level};
    assign out_below = lvl < OUT_LO;
    assign out_above = lvl > OUT_HI;
    assign in_below  = lvl < IN_LO;
    assign in_above  = lvl > IN_HI;

    assign side_out  = (state_q == S_EQ_OUT) || (state_q == S_OPEN_OUT);
    assign cur_below = side_out ? out_below : in_below;
    assign cur_above = side_out ? out_above : in_above;
    assign cur_ok    = !cur_below && !cur_above;
    assign oth_below = side_out ? in_below : out_below;
    assign oth_above = side_out ? in_above : out_above;

    assign occ_ok    = leg_q ? !gondola_in : gondola_in;
    assign pick_arr  = arr_pend_q && (!dept_pend_q || !last_arr_q);

    assign arr_led   = arr_pend_q;
    assign dept_led  = dept_pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            arr_pend_q  <= 1'b0;
            dept_pend_q <= 1'b0;
            last_arr_q  <= 1'b0;
            srv_arr_q   <= 1'b0;
            leg_q       <= 1'b0;
            dwell_q     <= '0;
            tmo_q       <= '0;
            fill_en     <= 1'b0;
            drain_en    <= 1'b0;
            outer_open  <= 1'b0;
            inner_open  <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arr_pend_q || dept_pend_q) begin
                        srv_arr_q  <= pick_arr;
                        last_arr_q <= pick_arr;
                        leg_q      <= 1'b0;
                        tmo_q      <= '0;
                        busy       <= 1'b1;
                        state_q    <= pick_arr ? S_EQ_OUT : S_EQ_IN;
                        fill_en    <= pick_arr ? out_below : in_below;
                        drain_en   <= pick_arr ? out_above : in_above;
                    end
                end
                S_EQ_OUT, S_EQ_IN: begin
                    if (cur_ok) begin
                        state_q    <= side_out ? S_OPEN_OUT : S_OPEN_IN;
                        fill_en    <= 1'b0;
                        drain_en   <= 1'b0;
                        outer_open <= side_out;
                        inner_open <= !side_out;
                        dwell_q    <= '0;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_q  <= S_FAULT;
                        fill_en  <= 1'b0;
                        drain_en <= 1'b0;
                        fault    <= 1'b1;
                    end else begin
                        tmo_q    <= tmo_q + 1'b1;
                        fill_en  <= cur_below;
                        drain_en <= cur_above;
                    end
                end
                S_OPEN_OUT, S_OPEN_IN: begin
                    if (!occ_ok) begin
                        dwell_q <= '0;
                    end else if (dwell_q != DW'(DWELL - 1)) begin
                        dwell_q <= dwell_q + 1'b1;
                    end else begin
                        outer_open <= 1'b0;
                        inner_open <= 1'b0;
                        if (!leg_q) begin
                            leg_q    <= 1'b1;
                            tmo_q    <= '0;
                            state_q  <= side_out ? S_EQ_IN : S_EQ_OUT;
                            fill_en  <= oth_below;
                            drain_en <= oth_above;
                        end else begin
                            state_q <= S_IDLE;
                            busy    <= 1'b0;
                            if (srv_arr_q) arr_pend_q  <= 1'b0;
                            else           dept_pend_q <= 1'b0;
                        end
                    end
                end
                default: ;  // FAULT holds until reset
            endcase
            // New requests are never lost, even on the edge that retires a passage.
            if (arr_sw)  arr_pend_q  <= 1'b1;
            if (dept_sw) dept_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lock_cycle_sequencer.sv
// Directed bench for lock_cycle_sequencer: passages, arbitration ties, timeout fault, async abort.
module tb_lock_cycle_sequencer;

    localparam int TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arr_sw = 1'b0, dept_sw = 1'b0, gondola_in = 1'b0;
    logic [6:0] water_level = 7'd50;
    logic       fill_en, drain_en, outer_open, inner_open, arr_led, dept_led, busy, fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_cycle_sequencer dut (
        .clk(clk), .reset(reset), .arr_sw(arr_sw), .dept_sw(dept_sw),
        .gondola_in(gondola_in), .water_level(water_level),
        .fill_en(fill_en), .drain_en(drain_en), .outer_open(outer_open),
        .inner_open(inner_open), .arr_led(arr_led), .dept_led(dept_led),
        .busy(busy), .fault(fault)
    );

    // Safety interlocks, checked every cycle while out of reset.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ((outer_open && inner_open) || ((fill_en || drain_en) && (outer_open || inner_open))) begin
                errors++;
                $display("FAIL interlock: fill=%b drain=%b outer=%b inner=%b", fill_en, drain_en, outer_open, inner_open);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        arr_sw = 0; dept_sw = 0; gondola_in = 0;
        reset = 0;
        tick; tick;
        reset = 1;
        tick;
    endtask

    task automatic test_reset;
        water_level = 50;
        #1 reset = 0;
        #2;
        checks++;
        if ({fill_en, drain_en, outer_open, inner_open, arr_led, dept_led, busy, fault} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {fill_en, drain_en, outer_open, inner_open, arr_led, dept_led, busy, fault});
        end
        tick; tick;
        reset = 1;
        repeat (10) begin
            tick;
            checks++;
            if ({fill_en, drain_en, outer_open, inner_open, arr_led, dept_led, busy, fault} !== 8'b0) begin
                errors++;
                $display("FAIL idle_outputs: got %b want 00000000",
                         {fill_en, drain_en, outer_open, inner_open, arr_led, dept_led, busy, fault});
            end
        end
    endtask

    task automatic test_arrival;
        water_level = 50;
        arr_sw = 1; tick; arr_sw = 0;
        checks++;
        if ({arr_led, busy} !== 2'b10) begin
            errors++; $display("FAIL arr_latch: got led/busy %b want 10", {arr_led, busy});
        end
        tick;
        checks++;
        if ({busy, fill_en, drain_en} !== 3'b101) begin
            errors++; $display("FAIL eq_out_drain: got busy/fill/drain %b want 101", {busy, fill_en, drain_en});
        end
        for (int l = 49; l >= 44; l--) begin water_level = 7'(l); tick; end
        checks++;
        if ({drain_en, outer_open} !== 2'b10) begin
            errors++; $display("FAIL band_edge_44: got drain/outer %b want 10", {drain_en, outer_open});
        end
        water_level = 43; tick;
        checks++;
        if ({drain_en, outer_open} !== 2'b01) begin
            errors++; $display("FAIL open_outer: got drain/outer %b want 01", {drain_en, outer_open});
        end
        gondola_in = 1;
        repeat (15) tick;
        checks++;
        if (outer_open !== 1'b1) begin
            errors++; $display("FAIL dwell_15: got outer %b want 1", outer_open);
        end
        tick;
        checks++;
        if ({outer_open, fill_en} !== 2'b01) begin
            errors++; $display("FAIL eq_in_fill: got outer/fill %b want 01", {outer_open, fill_en});
        end
        for (int l = 44; l <= 56; l++) begin water_level = 7'(l); tick; end
        checks++;
        if ({fill_en, inner_open} !== 2'b10) begin
            errors++; $display("FAIL band_edge_56: got fill/inner %b want 10", {fill_en, inner_open});
        end
        water_level = 57; tick;
        checks++;
        if ({fill_en, inner_open} !== 2'b01) begin
            errors++; $display("FAIL open_inner: got fill/inner %b want 01", {fill_en, inner_open});
        end
        gondola_in = 0;
        repeat (15) tick;
        checks++;
        if ({inner_open, arr_led} !== 2'b11) begin
            errors++; $display("FAIL exit_dwell_15: got inner/led %b want 11", {inner_open, arr_led});
        end
        tick;
        checks++;
        if ({inner_open, busy, arr_led} !== 3'b000) begin
            errors++; $display("FAIL arr_done: got inner/busy/led %b want 000", {inner_open, busy, arr_led});
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        water_level = 40;
        arr_sw = 1; dept_sw = 1; tick; arr_sw = 0; dept_sw = 0;
        checks++;
        if ({arr_led, dept_led, busy} !== 3'b110) begin
            errors++; $display("FAIL tie_latch: got arr/dept/busy %b want 110", {arr_led, dept_led, busy});
        end
        tick;
        checks++;
        if ({busy, fill_en, drain_en} !== 3'b100) begin
            errors++; $display("FAIL tie1_eq_out: got busy/fill/drain %b want 100", {busy, fill_en, drain_en});
        end
        tick;
        checks++;
        if ({outer_open, inner_open} !== 2'b10) begin
            errors++; $display("FAIL tie1_arrival: got outer/inner %b want 10", {outer_open, inner_open});
        end
        gondola_in = 1; repeat (16) tick;
        water_level = 60; tick;
        gondola_in = 0; repeat (16) tick;
        checks++;
        if ({busy, arr_led, dept_led} !== 3'b001) begin
            errors++; $display("FAIL arr_then_dept_pend: got busy/arr/dept %b want 001", {busy, arr_led, dept_led});
        end
        tick;
        checks++;
        if ({busy, fill_en, drain_en, outer_open} !== 4'b1000) begin
            errors++; $display("FAIL dept_eq_in: got busy/fill/drain/outer %b want 1000",
                               {busy, fill_en, drain_en, outer_open});
        end
        tick;
        checks++;
        if ({outer_open, inner_open} !== 2'b01) begin
            errors++; $display("FAIL dept_open_inner: got outer/inner %b want 01", {outer_open, inner_open});
        end
        gondola_in = 1; repeat (16) tick;
        checks++;
        if ({inner_open, drain_en} !== 2'b01) begin
            errors++; $display("FAIL dept_eq_out: got inner/drain %b want 01", {inner_open, drain_en});
        end
        water_level = 40; tick;
        checks++;
        if (outer_open !== 1'b1) begin
            errors++; $display("FAIL dept_open_outer: got %b want 1", outer_open);
        end
        gondola_in = 0; repeat (16) tick;
        checks++;
        if ({busy, dept_led} !== 2'b00) begin
            errors++; $display("FAIL dept_done: got busy/led %b want 00", {busy, dept_led});
        end
        // A lone arrival makes arrival the last served, so the next tie goes to departure.
        arr_sw = 1; tick; arr_sw = 0;
        tick; tick;
        gondola_in = 1; repeat (16) tick;
        water_level = 60; tick;
        gondola_in = 0; repeat (16) tick;
        checks++;
        if ({busy, arr_led} !== 2'b00) begin
            errors++; $display("FAIL lone_arr_done: got busy/led %b want 00", {busy, arr_led});
        end
        arr_sw = 1; dept_sw = 1; tick; arr_sw = 0; dept_sw = 0;
        tick;
        checks++;
        if ({busy, drain_en, fill_en} !== 3'b100) begin
            errors++; $display("FAIL tie2_eq_in: got busy/drain/fill %b want 100", {busy, drain_en, fill_en});
        end
        tick;
        checks++;
        if ({outer_open, inner_open} !== 2'b01) begin
            errors++; $display("FAIL tie2_departure: got outer/inner %b want 01", {outer_open, inner_open});
        end
    endtask

    task automatic test_timeout;
        do_reset;
        water_level = 40;
        arr_sw = 1; tick; arr_sw = 0;
        tick; tick;
        water_level = 50;
        gondola_in = 1; repeat (16) tick;
        checks++;
        if ({fill_en, fault} !== 2'b10) begin
            errors++; $display("FAIL tmo_entry: got fill/fault %b want 10", {fill_en, fault});
        end
        repeat (TIMEOUT - 1) tick;
        checks++;
        if ({fill_en, fault} !== 2'b10) begin
            errors++; $display("FAIL tmo_early: got fill/fault %b want 10", {fill_en, fault});
        end
        tick;
        checks++;
        if ({fault, fill_en, drain_en, outer_open, inner_open, busy, arr_led} !== 7'b1000011) begin
            errors++; $display("FAIL tmo_fault: got %b want 1000011",
                               {fault, fill_en, drain_en, outer_open, inner_open, busy, arr_led});
        end
        gondola_in = 0; water_level = 60;
        repeat (20) tick;
        checks++;
        if ({fault, inner_open, fill_en} !== 3'b100) begin
            errors++; $display("FAIL fault_sticky: got fault/inner/fill %b want 100", {fault, inner_open, fill_en});
        end
    endtask

    task automatic test_async_abort;
        do_reset;
        water_level = 40;
        arr_sw = 1; tick; arr_sw = 0;
        tick; tick;
        gondola_in = 1; repeat (16) tick;
        water_level = 60; tick;
        checks++;
        if (inner_open !== 1'b1) begin
            errors++; $display("FAIL abort_setup: got inner %b want 1", inner_open);
        end
        #2 reset = 0;
        #1;
        checks++;
        if ({inner_open, busy, fill_en, drain_en} !== 4'b0000) begin
            errors++; $display("FAIL abort_async: got inner/busy/fill/drain %b want 0000",
                               {inner_open, busy, fill_en, drain_en});
        end
        tick; tick;
        gondola_in = 0;
        reset = 1;
        repeat (5) tick;
        checks++;
        if ({busy, arr_led, dept_led, outer_open, inner_open} !== 5'b00000) begin
            errors++; $display("FAIL abort_idle: got busy/arr/dept/outer/inner %b want 00000",
                               {busy, arr_led, dept_led, outer_open, inner_open});
        end
    endtask

    initial begin
        test_reset;
        test_arrival;
        test_back_to_back;
        test_timeout;
        test_async_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
